// File: rtl/mc_datapath_mul.sv
// mc_datapath_mul: multicycle ARM datapath (PC, IR, data/operand regs,
// 15-entry register file, extender, ALU, muxes) plus an iterative
// shift-add multiplier whose product is selectable on the Result bus.
// Optional macro MC_DP_MUL_EARLY_EN: multiplier stops as soon as the
// remaining multiplier bits are all zero (same product, fewer cycles).
module mc_datapath_mul #(
  parameter int              WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] Adr,
  output logic [WIDTH-1:0] WriteData,
  input  logic [WIDTH-1:0] ReadData,
  output logic [WIDTH-1:0] Instr,
  output logic [3:0]       ALUFlags,
  input  logic             PCWrite,
  input  logic             RegWrite,
  input  logic             IRWrite,
  input  logic             AdrSrc,
  input  logic [1:0]       RegSrc,
  input  logic [1:0]       ALUSrcA,
  input  logic [1:0]       ALUSrcB,
  input  logic [1:0]       ResultSrc,
  input  logic [1:0]       ImmSrc,
  input  logic [1:0]       ALUControl,
  input  logic             MulStart,
  output logic             MulBusy,
  output logic             MulDone
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {M_IDLE, M_RUN, M_DONE} mstate_e;

  logic [WIDTH-1:0] pc_q, instr_q, data_q, a_q, wd_q, aluout_q, mulres_q, mulres_d;
  logic [WIDTH-1:0] rf_q [15];
  logic [WIDTH-1:0] result, rd1, rd2, ext_imm, srca, srcb, b_eff, alu_res;
  logic [WIDTH:0]   sum;
  logic [3:0]       ra1, ra2;
  logic             cflag, vflag;

  mstate_e          mstate_q, mstate_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;

  // Register-file addressing and reads; R15 reads see the Result bus
  always_comb begin
    ra1 = RegSrc[0] ? 4'hf : instr_q[19:16];
    ra2 = RegSrc[1] ? instr_q[15:12] : instr_q[3:0];
    rd1 = (ra1 == 4'hf) ? result : rf_q[ra1];
    rd2 = (ra2 == 4'hf) ? result : rf_q[ra2];
  end

  // Immediate extender
  always_comb begin
    case (ImmSrc)
      2'b00:   ext_imm = {{(WIDTH-8){1'b0}}, instr_q[7:0]};
      2'b01:   ext_imm = {{(WIDTH-12){1'b0}}, instr_q[11:0]};
      2'b10:   ext_imm = {{(WIDTH-26){instr_q[23]}}, instr_q[23:0], 2'b00};
      default: ext_imm = '0;
    endcase
  end

  // ALU operand muxes, ALU and flags; subtraction is A + ~B + 1
  always_comb begin
    case (ALUSrcA)
      2'b00:   srca = a_q;
      2'b01:   srca = pc_q;
      2'b10:   srca = aluout_q;
      default: srca = '0;
    endcase
    case (ALUSrcB)
      2'b00:   srcb = wd_q;
      2'b01:   srcb = ext_imm;
      2'b10:   srcb = WIDTH'(4);
      default: srcb = '0;
    endcase
    b_eff = ALUControl[0] ? ~srcb : srcb;
    sum   = {1'b0, srca} + {1'b0, b_eff} + (WIDTH+1)'(ALUControl[0]);
    cflag = 1'b0;
    vflag = 1'b0;
    case (ALUControl)
      2'b10:   alu_res = srca & srcb;
      2'b11:   alu_res = srca | srcb;
      default: begin
        alu_res = sum[WIDTH-1:0];
        cflag   = sum[WIDTH];
        vflag   = (srca[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != srca[WIDTH-1]);
      end
    endcase
    ALUFlags = {alu_res[WIDTH-1], alu_res == '0, cflag, vflag};
  end

  // Result bus and memory address
  always_comb begin
    case (ResultSrc)
      2'b00:   result = aluout_q;
      2'b01:   result = data_q;
      2'b10:   result = alu_res;
      default: result = mulres_q;
    endcase
    Adr = AdrSrc ? result : pc_q;
  end

  // Multiplier next state: one shift-add step per RUN cycle
  always_comb begin
    mstate_d = mstate_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    mulres_d = mulres_q;
    case (mstate_q)
      M_IDLE: if (MulStart) begin
        mcand_d  = a_q;
        mplier_d = wd_q;
        acc_d    = '0;
        count_d  = CW'(WIDTH);
        mstate_d = M_RUN;
      end
      M_RUN: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q - CW'(1);
`ifdef MC_DP_MUL_EARLY_EN
        if (count_d == '0 || mplier_d == '0) begin
`else
        if (count_d == '0) begin
`endif
          mulres_d = acc_d;
          mstate_d = M_DONE;
        end
      end
      default: mstate_d = M_IDLE;
    endcase
  end

  assign MulBusy   = (mstate_q == M_RUN);
  assign MulDone   = (mstate_q == M_DONE);
  assign Instr     = instr_q;
  assign WriteData = wd_q;

  // Datapath and multiplier registers; reset aborts any multiply silently
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      data_q   <= '0;
      a_q      <= '0;
      wd_q     <= '0;
      aluout_q <= '0;
      mulres_q <= '0;
      mstate_q <= M_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else begin
      if (PCWrite) pc_q    <= result;
      if (IRWrite) instr_q <= ReadData;
      data_q   <= ReadData;
      a_q      <= rd1;
      wd_q     <= rd2;
      aluout_q <= alu_res;
      mulres_q <= mulres_d;
      mstate_q <= mstate_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
    end
  end

  // Register file R0-R14; writes aimed at R15 are dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) rf_q[i] <= '0;
    end else if (RegWrite && instr_q[15:12] != 4'hf) begin
      rf_q[instr_q[15:12]] <= result;
    end
  end

endmodule

// File: tb/tb_mc_datapath_mul.sv
// Bench for mc_datapath_mul: directed tasks per feature; multiplier
// products are tracked through a scoreboard queue.
module tb_mc_datapath_mul;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Adr, WriteData, ReadData, Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, RegWrite, IRWrite, AdrSrc, MulStart, MulBusy, MulDone;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

  int pass_cnt = 0;
  int total    = 0;
  logic [31:0] exp_q [$];

  mc_datapath_mul #(.WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .Adr(Adr), .WriteData(WriteData), .ReadData(ReadData),
    .Instr(Instr), .ALUFlags(ALUFlags), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .MulStart(MulStart), .MulBusy(MulBusy), .MulDone(MulDone)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl_default();
    PCWrite = 0; RegWrite = 0; IRWrite = 0; AdrSrc = 0; MulStart = 0;
    RegSrc = 0; ALUSrcA = 0; ALUSrcB = 0; ResultSrc = 0; ImmSrc = 0; ALUControl = 0;
    ReadData = 0;
  endtask

  task automatic load_instr(input logic [31:0] v);
    ctl_default(); ReadData = v; IRWrite = 1; tick(); ctl_default();
  endtask

  // Route a value through the Data register into register rd
  task automatic write_reg(input logic [3:0] rd, input logic [31:0] v);
    load_instr({16'h0, rd, 12'h0});
    ReadData = v; tick();
    ResultSrc = 2'b01; RegWrite = 1; tick();
    ctl_default();
  endtask

  function automatic int iters(input logic [31:0] b);
    for (int i = 31; i >= 0; i--) if (b[i]) return i + 1;
    return 1;
  endfunction

  task automatic test_reset();
    reset = 1; ctl_default();
    tick(); tick();
    reset = 0; #1;
    total++; if (Adr !== 32'h0) $display("FAIL reset_pc: got %h want 00000000", Adr); else pass_cnt++;
    total++; if (Instr !== 32'h0) $display("FAIL reset_instr: got %h want 00000000", Instr); else pass_cnt++;
    total++; if (ALUFlags !== 4'b0100) $display("FAIL reset_flags: got %b want 0100", ALUFlags); else pass_cnt++;
    total++; if ({MulBusy, MulDone} !== 2'b00) $display("FAIL reset_mul: got %b want 00", {MulBusy, MulDone}); else pass_cnt++;
    AdrSrc = 1; ResultSrc = 2'b11; #1;
    total++; if (Adr !== 32'h0) $display("FAIL reset_mulres: got %h want 00000000", Adr); else pass_cnt++;
    ctl_default();
  endtask

  task automatic test_fetch();
    ctl_default();
    ReadData = 32'hE2801005; IRWrite = 1; ALUSrcA = 2'b01; ALUSrcB = 2'b10;
    ResultSrc = 2'b10; PCWrite = 1;
    tick(); ctl_default(); #1;
    total++; if (Instr !== 32'hE2801005) $display("FAIL fetch_instr: got %h want e2801005", Instr); else pass_cnt++;
    total++; if (Adr !== 32'h4) $display("FAIL fetch_pc: got %h want 00000004", Adr); else pass_cnt++;
  endtask

  task automatic test_alu();
    tick();  // decode: A <= R0
    ALUSrcA = 2'b00; ALUSrcB = 2'b01; ImmSrc = 2'b00; ALUControl = 2'b00;
    ResultSrc = 2'b10; AdrSrc = 1; #1;
    total++; if (Adr !== 32'h5) $display("FAIL add_imm: got %h want 00000005", Adr); else pass_cnt++;
    tick();
    ResultSrc = 2'b00; RegWrite = 1; #1;
    total++; if (Adr !== 32'h5) $display("FAIL aluout: got %h want 00000005", Adr); else pass_cnt++;
    tick();
    load_instr(32'h00011001); tick();  // A = WriteData = R1
    total++; if (WriteData !== 32'h5) $display("FAIL r1_write: got %h want 00000005", WriteData); else pass_cnt++;
    ALUSrcA = 2'b00; ALUSrcB = 2'b00; ALUControl = 2'b01; #1;
    total++; if (ALUFlags !== 4'b0110) $display("FAIL sub_flags: got %b want 0110", ALUFlags); else pass_cnt++;
    ALUSrcB = 2'b01; ImmSrc = 2'b00; ALUControl = 2'b10; ResultSrc = 2'b10; AdrSrc = 1; #1;
    total++; if (Adr !== 32'h1 || ALUFlags !== 4'b0000) $display("FAIL and_op: got %h/%b want 00000001/0000", Adr, ALUFlags); else pass_cnt++;
    ALUControl = 2'b11; #1;
    total++; if (Adr !== 32'h5) $display("FAIL or_op: got %h want 00000005", Adr); else pass_cnt++;
    // overflow and borrow boundaries
    write_reg(4'd2, 32'h7FFFFFFF); write_reg(4'd3, 32'h1);
    load_instr(32'h00020003); tick();
    ALUSrcA = 2'b00; ALUSrcB = 2'b00; ALUControl = 2'b00; ResultSrc = 2'b10; AdrSrc = 1; #1;
    total++; if (ALUFlags !== 4'b1001 || Adr !== 32'h80000000) $display("FAIL add_ovf: got %b/%h want 1001/80000000", ALUFlags, Adr); else pass_cnt++;
    ALUControl = 2'b01; #1;
    total++; if (ALUFlags !== 4'b0010 || Adr !== 32'h7FFFFFFE) $display("FAIL sub_nb: got %b/%h want 0010/7ffffffe", ALUFlags, Adr); else pass_cnt++;
    ctl_default();
  endtask

  task automatic test_ext();
    load_instr(32'h00800A53);
    ALUSrcA = 2'b11; ALUSrcB = 2'b01; ALUControl = 2'b00; ResultSrc = 2'b10; AdrSrc = 1;
    ImmSrc = 2'b00; #1;
    total++; if (Adr !== 32'h53) $display("FAIL ext_imm8: got %h want 00000053", Adr); else pass_cnt++;
    ImmSrc = 2'b01; #1;
    total++; if (Adr !== 32'hA53) $display("FAIL ext_imm12: got %h want 00000a53", Adr); else pass_cnt++;
    ImmSrc = 2'b10; #1;
    total++; if (Adr !== 32'hFE00294C) $display("FAIL ext_br: got %h want fe00294c", Adr); else pass_cnt++;
    ImmSrc = 2'b11; #1;
    total++; if (Adr !== 32'h0) $display("FAIL ext_zero: got %h want 00000000", Adr); else pass_cnt++;
    ctl_default();
  endtask

  task automatic prep_mul(input logic [31:0] a, input logic [31:0] b);
    write_reg(4'd2, a); write_reg(4'd3, b);
    load_instr(32'h00020003); tick();
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input bit hold);
    int busy = 0, done = 0, dcyc = 0, exp_n;
    logic [31:0] e;
    logic [31:0] prod;
    prod = a * b;
    exp_q.push_back(prod);
`ifdef MC_DP_MUL_EARLY_EN
    exp_n = iters(b);
`else
    exp_n = 32;
`endif
    ctl_default(); AdrSrc = 1; ResultSrc = 2'b11; MulStart = 1;
    tick();
    MulStart = hold;
    for (int c = 1; c <= 80; c++) begin
      if (MulBusy) busy++;
      if (MulDone) begin
        done++; dcyc = c;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          total++; if (Adr !== e) $display("FAIL mul_result: got %h want %h", Adr, e); else pass_cnt++;
        end
      end
      tick();
      MulStart = 0;
    end
    total++; if (busy != exp_n) $display("FAIL mul_busy_cycles: got %0d want %0d", busy, exp_n); else pass_cnt++;
    total++; if (done != 1 || dcyc != exp_n + 1) $display("FAIL mul_done: got %0d pulses at %0d want 1 at %0d", done, dcyc, exp_n + 1); else pass_cnt++;
    total++; if (exp_q.size() != 0) begin
      $display("FAIL mul_timeout: got %0d pending want 0", exp_q.size()); exp_q.delete();
    end else pass_cnt++;
    total++; if (Adr !== prod) $display("FAIL mul_hold: got %h want %h", Adr, prod); else pass_cnt++;
    ctl_default();
  endtask

  task automatic test_mul();
    prep_mul(32'd7, 32'd6);             run_mul(32'd7, 32'd6, 0);
    prep_mul(32'hFFFFFFFF, 32'd2);      run_mul(32'hFFFFFFFF, 32'd2, 1);
    prep_mul(32'h12345678, 32'h9ABCDEF1); run_mul(32'h12345678, 32'h9ABCDEF1, 0);
  endtask

  task automatic test_back_to_back();
    prep_mul(32'd5, 32'd0); run_mul(32'd5, 32'd0, 0);
    run_mul(32'd5, 32'd0, 0);
  endtask

  task automatic test_reset_abort();
    int dones = 0;
    prep_mul(32'd3, 32'h80000001);
    ctl_default(); AdrSrc = 1; ResultSrc = 2'b11; MulStart = 1; tick(); MulStart = 0;
    repeat (10) tick();
    total++; if (MulBusy !== 1'b1) $display("FAIL abort_busy_before: got %b want 1", MulBusy); else pass_cnt++;
    reset = 1; tick(); reset = 0; #1;
    total++; if (MulBusy !== 1'b0 || Adr !== 32'h0) $display("FAIL abort_state: got %b/%h want 0/00000000", MulBusy, Adr); else pass_cnt++;
    for (int c = 0; c < 40; c++) begin
      if (MulDone) dones++;
      tick();
    end
    total++; if (dones != 0) $display("FAIL abort_done: got %0d want 0", dones); else pass_cnt++;
    prep_mul(32'd13, 32'd17); run_mul(32'd13, 32'd17, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; ctl_default();
    test_reset();
    test_fetch();
    test_alu();
    test_ext();
    test_mul();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
